// File: rtl/vaccine_hit_reporter_if.sv
// Collision interface between the vaccine hit reporter (master) and the
// vaccine position manager / frame logic (slave).
interface vaccine_hit_reporter_if #(
    parameter int NUM_VACCINES = 10,
    parameter int INDEX_W      = 4,
    parameter int SCORE_W      = 8
);
    logic                    startOfFrame;
    logic                    clamp_draw_request;
    logic [0:NUM_VACCINES-1] vaccines_draw_request;
    logic                    collision;
    logic [0:INDEX_W-1]      collision_clamp_vaccine;
    logic                    busy;
    logic [SCORE_W-1:0]      score;

    modport master (
        input  startOfFrame,
        input  clamp_draw_request,
        input  vaccines_draw_request,
        output collision,
        output collision_clamp_vaccine,
        output busy,
        output score
    );

    modport slave (
        output startOfFrame,
        output clamp_draw_request,
        output vaccines_draw_request,
        input  collision,
        input  collision_clamp_vaccine,
        input  busy,
        input  score
    );
endinterface

// File: rtl/vaccine_hit_reporter.sv
// Accumulates clamp/vaccine pixel overlaps over a frame and, from each
// start-of-frame snapshot, reports every hit vaccine as one collision pulse.
module vaccine_hit_reporter #(
    parameter int NUM_VACCINES = 10,
    parameter int INDEX_W      = 4,
    parameter int GAP_CYCLES   = 1,
    parameter int SCORE_W      = 8
) (
    input  logic                   clk,
    input  logic                   resetN,
    vaccine_hit_reporter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [2:0]         GAP_LAST  = (GAP_CYCLES > 0) ? 3'(GAP_CYCLES - 1) : 3'd0;
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    // Index 0 has the highest priority, so the last match scanning downward wins.
    function automatic logic [INDEX_W-1:0] lowest_index(input logic [0:NUM_VACCINES-1] vec);
        logic [INDEX_W-1:0] idx;
        idx = {INDEX_W{1'b0}};
        for (int i = NUM_VACCINES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = INDEX_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [0:NUM_VACCINES-1] index_mask(input logic [INDEX_W-1:0] idx);
        logic [0:NUM_VACCINES-1] mask;
        mask = {NUM_VACCINES{1'b0}};
        for (int i = 0; i < NUM_VACCINES; i++) begin
            if (INDEX_W'(i) == idx) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

    state_t                  state_r;
    state_t                  state_next_s;
    logic [2:0]              gap_cnt_r;
    logic [0:NUM_VACCINES-1] hit_s;
    logic [0:NUM_VACCINES-1] acc_r;
    logic [0:NUM_VACCINES-1] acc_next_s;
    logic [0:NUM_VACCINES-1] pending_r;
    logic [0:NUM_VACCINES-1] pending_next_s;
    logic [0:NUM_VACCINES-1] clr_mask_s;
    logic                    emit_s;
    logic [INDEX_W-1:0]      emit_idx_s;
    logic                    collision_r;
    logic [INDEX_W-1:0]      index_r;
    logic                    busy_r;
    logic [SCORE_W-1:0]      score_r;

    // Per-pixel overlap of the clamp with each vaccine.
    always_comb begin
        hit_s = {NUM_VACCINES{bus.clamp_draw_request}} & bus.vaccines_draw_request;
    end

    // State register and gap counter.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r   <= ST_IDLE;
            gap_cnt_r <= 3'd0;
        end else begin
            state_r   <= state_next_s;
            gap_cnt_r <= (state_r == ST_GAP && state_next_s == ST_GAP) ? gap_cnt_r + 3'd1 : 3'd0;
        end
    end

    // Next-state logic; decisions use pending as already cleared by the last pulse.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pending_r != {NUM_VACCINES{1'b0}}) begin
                    state_next_s = ST_EMIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (GAP_CYCLES > 0) begin
                    state_next_s = ST_GAP;
                end else if (pending_r != {NUM_VACCINES{1'b0}}) begin
                    state_next_s = ST_EMIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r != GAP_LAST) begin
                    state_next_s = ST_GAP;
                end else if (pending_r != {NUM_VACCINES{1'b0}}) begin
                    state_next_s = ST_EMIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output/datapath decode: a pulse is launched on every edge that enters EMIT,
    // and its bit is cleared before any start-of-frame merge.
    always_comb begin
        emit_s     = (state_next_s == ST_EMIT);
        emit_idx_s = lowest_index(pending_r);
        if (emit_s) begin
            clr_mask_s = index_mask(emit_idx_s);
        end else begin
            clr_mask_s = {NUM_VACCINES{1'b0}};
        end
        if (bus.startOfFrame) begin
            pending_next_s = (pending_r & ~clr_mask_s) | acc_r | hit_s;
            acc_next_s     = {NUM_VACCINES{1'b0}};
        end else begin
            pending_next_s = pending_r & ~clr_mask_s;
            acc_next_s     = acc_r | hit_s;
        end
    end

    // Hit accumulator, pending snapshot and registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            acc_r       <= {NUM_VACCINES{1'b0}};
            pending_r   <= {NUM_VACCINES{1'b0}};
            collision_r <= 1'b0;
            index_r     <= {INDEX_W{1'b0}};
            busy_r      <= 1'b0;
            score_r     <= {SCORE_W{1'b0}};
        end else begin
            acc_r       <= acc_next_s;
            pending_r   <= pending_next_s;
            collision_r <= emit_s;
            index_r     <= emit_s ? emit_idx_s : {INDEX_W{1'b0}};
            busy_r      <= (pending_next_s != {NUM_VACCINES{1'b0}}) || (state_next_s != ST_IDLE);
            if (emit_s && score_r != SCORE_MAX) begin
                score_r <= score_r + {{(SCORE_W-1){1'b0}}, 1'b1};
            end else begin
                score_r <= score_r;
            end
        end
    end

    assign bus.collision               = collision_r;
    assign bus.collision_clamp_vaccine = index_r;
    assign bus.busy                    = busy_r;
    assign bus.score                   = score_r;

endmodule

// File: tb/tb_vaccine_hit_reporter.sv
// Directed bench for vaccine_hit_reporter: a default instance plus a 2-bit
// score instance driven with identical stimulus.
module tb_vaccine_hit_reporter;

    logic clk    = 1'b0;
    logic resetN = 1'b0;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    int   q_idx[$];
    int   q_cyc[$];
    int   s_cnt    = 0;
    int   idle_bad = 0;

    always #5 clk = ~clk;

    vaccine_hit_reporter_if #(.NUM_VACCINES(10), .INDEX_W(4), .SCORE_W(8)) a_if ();
    vaccine_hit_reporter_if #(.NUM_VACCINES(10), .INDEX_W(4), .SCORE_W(2)) s_if ();

    vaccine_hit_reporter #(.NUM_VACCINES(10), .INDEX_W(4), .GAP_CYCLES(1), .SCORE_W(8)) dut_a (
        .clk    (clk),
        .resetN (resetN),
        .bus    (a_if.master)
    );

    vaccine_hit_reporter #(.NUM_VACCINES(10), .INDEX_W(4), .GAP_CYCLES(1), .SCORE_W(2)) dut_s (
        .clk    (clk),
        .resetN (resetN),
        .bus    (s_if.master)
    );

    // Cycle count; a pulse logged with value k was launched by posedge k.
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse logger, sampled mid-cycle.
    always @(negedge clk) begin
        if (a_if.collision) begin
            q_idx.push_back(int'(a_if.collision_clamp_vaccine));
            q_cyc.push_back(cyc);
        end else if (a_if.collision_clamp_vaccine != 4'd0) begin
            idle_bad <= idle_bad + 1;
        end
        if (s_if.collision) s_cnt <= s_cnt + 1;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic c, input logic [0:9] v, input logic sof);
        a_if.clamp_draw_request    = c;
        a_if.vaccines_draw_request = v;
        a_if.startOfFrame          = sof;
        s_if.clamp_draw_request    = c;
        s_if.vaccines_draw_request = v;
        s_if.startOfFrame          = sof;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 10'b0, 1'b0);
    endtask

    task automatic check_pulse(input string tag, input int k, input int exp_idx, input int exp_cyc);
        if (k < q_idx.size()) begin
            check_eq({tag, "_idx"}, q_idx[k], exp_idx);
            check_eq({tag, "_cyc"}, q_cyc[k], exp_cyc);
        end else begin
            check_eq({tag, "_missing"}, -1, exp_idx);
        end
    endtask

    initial begin
        logic [0:9] v;
        int s;
        int base;
        int sbase;
        int exp4[11];

        a_if.clamp_draw_request = 1'b0; a_if.vaccines_draw_request = 10'b0; a_if.startOfFrame = 1'b0;
        s_if.clamp_draw_request = 1'b0; s_if.vaccines_draw_request = 10'b0; s_if.startOfFrame = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_collision", int'(a_if.collision), 0);
        check_eq("rst_index", int'(a_if.collision_clamp_vaccine), 0);
        check_eq("rst_busy", int'(a_if.busy), 0);
        check_eq("rst_score", int'(a_if.score), 0);
        resetN = 1'b1;
        idle(2);

        // Reset in the middle of a pulse with vaccines 0 and 1 pending.
        v = 10'b0; v[0] = 1'b1; v[1] = 1'b1;
        drive(1'b1, v, 1'b1);
        idle(1);
        check_eq("t1_pulse_before_reset", int'(a_if.collision), 1);
        resetN = 1'b0;
        #1;
        check_eq("t1_collision", int'(a_if.collision), 0);
        check_eq("t1_score", int'(a_if.score), 0);
        check_eq("t1_busy", int'(a_if.busy), 0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        base = q_idx.size();
        idle(10);
        check_eq("t1_no_pulse_after", q_idx.size() - base, 0);

        // Single vaccine overlapped for 40 pixels.
        base = q_idx.size();
        v = 10'b0; v[3] = 1'b1;
        repeat (40) drive(1'b1, v, 1'b0);
        idle(3);
        s = cyc;
        drive(1'b0, 10'b0, 1'b1);
        check_eq("t2_busy", int'(a_if.busy), 1);
        idle(14);
        check_eq("t2_count", q_idx.size() - base, 1);
        check_pulse("t2_p0", base, 3, s + 2);
        check_eq("t2_score", int'(a_if.score), 1);

        // Vaccines 7, 2, 9 hit; reported in index order with one idle gap.
        base = q_idx.size();
        v = 10'b0; v[7] = 1'b1; drive(1'b1, v, 1'b0);
        v = 10'b0; v[2] = 1'b1; drive(1'b1, v, 1'b0);
        v = 10'b0; v[9] = 1'b1; drive(1'b1, v, 1'b0);
        idle(2);
        s = cyc;
        drive(1'b0, 10'b0, 1'b1);
        idle(14);
        check_eq("t3_count", q_idx.size() - base, 3);
        check_pulse("t3_p0", base,     2, s + 2);
        check_pulse("t3_p1", base + 1, 7, s + 4);
        check_pulse("t3_p2", base + 2, 9, s + 6);
        check_eq("t3_score", int'(a_if.score), 4);
        check_eq("t3_busy_done", int'(a_if.busy), 0);

        // Vaccines requested without clamp never count; a hit on the frame-start cycle does.
        base = q_idx.size();
        repeat (5) drive(1'b0, 10'b1111111111, 1'b0);
        s = cyc;
        v = 10'b0; v[5] = 1'b1;
        drive(1'b1, v, 1'b1);
        idle(10);
        check_eq("t5_count", q_idx.size() - base, 1);
        check_pulse("t5_p0", base, 5, s + 2);
        check_eq("t5_score", int'(a_if.score), 5);
        drive(1'b0, 10'b0, 1'b1);
        idle(6);
        check_eq("t5_empty_frame", q_idx.size() - base, 1);

        // All ten pending; vaccine 1 re-hit and a new frame starts after the fourth pulse.
        base = q_idx.size();
        drive(1'b1, 10'b1111111111, 1'b0);
        idle(1);
        s = cyc;
        drive(1'b0, 10'b0, 1'b1);
        idle(6);
        v = 10'b0; v[1] = 1'b1;
        drive(1'b1, v, 1'b0);
        drive(1'b0, 10'b0, 1'b1);
        idle(30);
        exp4 = '{0, 1, 2, 3, 1, 4, 5, 6, 7, 8, 9};
        check_eq("t4_count", q_idx.size() - base, 11);
        for (int k = 0; k < 11; k++) begin
            check_pulse($sformatf("t4_p%0d", k), base + k, exp4[k], s + 2 + 2 * k);
        end
        check_eq("t4_score", int'(a_if.score), 16);

        // Saturating 2-bit score over five hits.
        resetN = 1'b0;
        @(posedge clk);
        #1;
        resetN = 1'b1;
        base  = q_idx.size();
        sbase = s_cnt;
        drive(1'b1, 10'b1111100000, 1'b0);
        drive(1'b0, 10'b0, 1'b1);
        idle(16);
        check_eq("t6_sat_pulses", s_cnt - sbase, 5);
        check_eq("t6_sat_score", int'(s_if.score), 3);
        check_eq("t6_wide_score", int'(a_if.score), 5);
        check_eq("t6_wide_pulses", q_idx.size() - base, 5);

        check_eq("idle_index_zero", idle_bad, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
